// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a synchronous single-port RAM.
// One access in flight at a time; every output comes straight from a register.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  A_REQ,
  input  logic                  A_RW,
  input  logic [ADDR_WIDTH-1:0] A_ADDR,
  input  logic [DATA_WIDTH-1:0] A_WDATA,
  output logic                  A_ACK,
  output logic [DATA_WIDTH-1:0] A_RDATA,
  input  logic                  B_REQ,
  input  logic                  B_RW,
  input  logic [ADDR_WIDTH-1:0] B_ADDR,
  input  logic [DATA_WIDTH-1:0] B_WDATA,
  output logic                  B_ACK,
  output logic [DATA_WIDTH-1:0] B_RDATA,
  output logic                  MEM_CS,
  output logic                  MEM_RW,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

  typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, ACKN} state_t;
  typedef enum logic {PORT_A, PORT_B} port_t;

  state_t state;
  port_t  last_grant;
  port_t  grant;
  logic   pick_b;

  // B wins when it is the only requester, or on contention when A was served last.
  always_comb begin
    pick_b = B_REQ && (!A_REQ || (last_grant == PORT_A));
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking ones would make ordering matter.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state      <= IDLE;
      last_grant <= PORT_B;
      grant      <= PORT_A;
      MEM_CS     <= 1'b0;
      MEM_RW     <= 1'b0;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      A_ACK      <= 1'b0;
      B_ACK      <= 1'b0;
      A_RDATA    <= '0;
      B_RDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (A_REQ || B_REQ) begin
            if (pick_b) begin
              MEM_RW     <= B_RW;
              MEM_ADDR   <= B_ADDR;
              MEM_WDATA  <= B_WDATA;
              grant      <= PORT_B;
              last_grant <= PORT_B;
            end else begin
              MEM_RW     <= A_RW;
              MEM_ADDR   <= A_ADDR;
              MEM_WDATA  <= A_WDATA;
              grant      <= PORT_A;
              last_grant <= PORT_A;
            end
            MEM_CS <= 1'b1;
            state  <= ACCESS;
          end else begin
            MEM_CS <= 1'b0;
          end
        end
        ACCESS: begin
          MEM_CS <= 1'b0;
          state  <= CAPTURE;
        end
        CAPTURE: begin
          // RAM output is valid this cycle (writes echo the write data).
          if (grant == PORT_B) begin
            B_RDATA <= MEM_RDATA;
            B_ACK   <= 1'b1;
          end else begin
            A_RDATA <= MEM_RDATA;
            A_ACK   <= 1'b1;
          end
          state <= ACKN;
        end
        ACKN: begin
          A_ACK <= 1'b0;
          B_ACK <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 4096x16 registered-output RAM.
module tb_mem_arbiter;

  logic        Clock = 1'b0;
  logic        Reset_n;
  logic        A_REQ, A_RW, B_REQ, B_RW;
  logic [15:0] A_ADDR, A_WDATA, B_ADDR, B_WDATA;
  logic        A_ACK, B_ACK;
  logic [15:0] A_RDATA, B_RDATA;
  logic        MEM_CS, MEM_RW;
  logic [15:0] MEM_ADDR, MEM_WDATA;
  logic [15:0] MEM_RDATA = 16'h0000;

  int total = 0;
  int bad   = 0;

  logic [15:0] ram [0:4095] = '{16: 16'hBEEF, 1: 16'h1111, 2: 16'h2222,
                                3: 16'h3333, 4: 16'h4444, default: 16'h0000};

  mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .Clock(Clock), .Reset_n(Reset_n),
    .A_REQ(A_REQ), .A_RW(A_RW), .A_ADDR(A_ADDR), .A_WDATA(A_WDATA),
    .A_ACK(A_ACK), .A_RDATA(A_RDATA),
    .B_REQ(B_REQ), .B_RW(B_RW), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_ACK(B_ACK), .B_RDATA(B_RDATA),
    .MEM_CS(MEM_CS), .MEM_RW(MEM_RW), .MEM_ADDR(MEM_ADDR),
    .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA)
  );

  always #5 Clock = ~Clock;

  // RAM: samples on CS, registered output, writes echo the write data; not reset.
  always @(posedge Clock) begin
    if (MEM_CS) begin
      if (MEM_RW) begin
        ram[MEM_ADDR[11:0]] <= MEM_WDATA;
        MEM_RDATA           <= MEM_WDATA;
      end else begin
        MEM_RDATA <= ram[MEM_ADDR[11:0]];
      end
    end
  end

  // Counts falling edges until the chosen port acks; gives up after 12.
  task automatic wait_ack(input bit port_b, output int cycles);
    cycles = 0;
    do begin
      @(negedge Clock);
      cycles++;
    end while (!(port_b ? B_ACK : A_ACK) && cycles < 12);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    A_REQ = 0; A_RW = 0; A_ADDR = '0; A_WDATA = '0;
    B_REQ = 0; B_RW = 0; B_ADDR = '0; B_WDATA = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    total++;
    if ({MEM_CS, MEM_RW, MEM_ADDR, MEM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: cs=%b rw=%b addr=%h wd=%h aack=%b back=%b ard=%h brd=%h, required all zero",
               MEM_CS, MEM_RW, MEM_ADDR, MEM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA);
    end
    Reset_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge Clock);
    A_REQ = 1; A_RW = 0; A_ADDR = 16'h0010;
    @(negedge Clock);
    total++;
    if ({MEM_CS, MEM_RW, MEM_ADDR, A_ACK} !== {1'b1, 1'b0, 16'h0010, 1'b0}) begin
      bad++;
      $display("FAIL single_access: cs=%b rw=%b addr=%h ack=%b, required cs=1 rw=0 addr=0010 ack=0",
               MEM_CS, MEM_RW, MEM_ADDR, A_ACK);
    end
    @(negedge Clock);
    total++;
    if ({MEM_CS, A_ACK} !== 2'b00) begin
      bad++;
      $display("FAIL single_capture: cs=%b ack=%b, required 0 0", MEM_CS, A_ACK);
    end
    @(negedge Clock);
    total++;
    if ({A_ACK, A_RDATA, B_ACK} !== {1'b1, 16'hBEEF, 1'b0}) begin
      bad++;
      $display("FAIL single_ack: aack=%b ardata=%h back=%b, required 1 beef 0", A_ACK, A_RDATA, B_ACK);
    end
    A_REQ = 0;
    @(negedge Clock);
    total++;
    if ({A_ACK, A_RDATA} !== {1'b0, 16'hBEEF}) begin
      bad++;
      $display("FAIL single_hold: aack=%b ardata=%h, required 0 beef", A_ACK, A_RDATA);
    end
  endtask

  task automatic test_write_readback();
    int lat;
    @(negedge Clock);
    B_REQ = 1; B_RW = 1; B_ADDR = 16'h0FFF; B_WDATA = 16'h1234;
    wait_ack(1'b1, lat);
    total++;
    if (lat !== 3 || B_RDATA !== 16'h1234 || A_ACK !== 1'b0) begin
      bad++;
      $display("FAIL b_write: latency=%0d brdata=%h aack=%b, required 3 1234 0", lat, B_RDATA, A_ACK);
    end
    B_RW = 0; B_WDATA = 16'h0000;
    wait_ack(1'b1, lat);
    total++;
    if (lat !== 4 || B_RDATA !== 16'h1234) begin
      bad++;
      $display("FAIL b_readback: latency=%0d brdata=%h, required 4 1234", lat, B_RDATA);
    end
    B_REQ = 0;
  endtask

  task automatic test_simultaneous();
    int first_cs = -1, second_cs = -1, a_acks = 0, b_acks = 0;
    logic [15:0] first_addr = '0, second_addr = '0;
    @(negedge Clock);
    Reset_n = 0;
    @(negedge Clock);
    Reset_n = 1;
    A_REQ = 1; A_RW = 0; A_ADDR = 16'h0010;
    B_REQ = 1; B_RW = 0; B_ADDR = 16'h0FFF;
    for (int c = 1; c <= 12; c++) begin
      @(negedge Clock);
      if (MEM_CS) begin
        if (first_cs < 0) begin first_cs = c; first_addr = MEM_ADDR; end
        else if (second_cs < 0) begin second_cs = c; second_addr = MEM_ADDR; end
      end
      if (A_ACK) begin
        a_acks++;
        total++;
        if (A_RDATA !== 16'hBEEF) begin
          bad++;
          $display("FAIL simul_a_data: ardata=%h, required beef", A_RDATA);
        end
        A_REQ = 0;
      end
      if (B_ACK) begin
        b_acks++;
        total++;
        if (B_RDATA !== 16'h1234) begin
          bad++;
          $display("FAIL simul_b_data: brdata=%h, required 1234", B_RDATA);
        end
        B_REQ = 0;
      end
    end
    total++;
    if (first_cs !== 1 || first_addr !== 16'h0010 || second_cs !== 5 || second_addr !== 16'h0FFF) begin
      bad++;
      $display("FAIL simul_order: cs cycles %0d/%0d addrs %h/%h, required 1/5 0010/0fff",
               first_cs, second_cs, first_addr, second_addr);
    end
    total++;
    if (a_acks !== 1 || b_acks !== 1) begin
      bad++;
      $display("FAIL simul_ack_count: a=%0d b=%0d, required 1 1", a_acks, b_acks);
    end
  endtask

  task automatic test_contention();
    logic [7:0] order = '0;
    int n = 0;
    bit both = 0;
    @(negedge Clock);
    A_REQ = 1; A_RW = 0; A_ADDR = 16'h0010;
    B_REQ = 1; B_RW = 0; B_ADDR = 16'h0FFF;
    for (int c = 0; c < 50 && n < 8; c++) begin
      @(negedge Clock);
      if (A_ACK && B_ACK) both = 1;
      if (A_ACK) begin
        order[n] = 1'b0;
        n++;
        total++;
        if (A_RDATA !== 16'hBEEF) begin
          bad++;
          $display("FAIL contend_a_data: ardata=%h, required beef", A_RDATA);
        end
      end else if (B_ACK) begin
        order[n] = 1'b1;
        n++;
        total++;
        if (B_RDATA !== 16'h1234) begin
          bad++;
          $display("FAIL contend_b_data: brdata=%h, required 1234", B_RDATA);
        end
      end
    end
    A_REQ = 0; B_REQ = 0;
    total++;
    if (n !== 8 || order !== 8'b1010_1010 || both) begin
      bad++;
      $display("FAIL contend_order: grants=%0d order(bit i = B)=%b both_ack=%b, required 8 10101010 0",
               n, order, both);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    @(negedge Clock);
    A_REQ = 1; A_RW = 0; A_ADDR = 16'h0001;
    for (int i = 1; i <= 4; i++) begin
      wait_ack(1'b0, lat);
      total++;
      if (lat !== ((i == 1) ? 3 : 4) || A_RDATA !== 16'(16'h1111 * i) ||
          B_ACK !== 1'b0 || B_RDATA !== 16'h1234) begin
        bad++;
        $display("FAIL b2b_read_%0d: latency=%0d ardata=%h back=%b brdata=%h, required %0d %h 0 1234",
                 i, lat, A_RDATA, B_ACK, B_RDATA, (i == 1) ? 3 : 4, 16'(16'h1111 * i));
      end
      A_ADDR = 16'(i + 1);
    end
    A_REQ = 0;
  endtask

  task automatic test_reset_mid_access();
    int lat;
    bit ack_seen = 0;
    @(negedge Clock);
    A_REQ = 1; A_RW = 1; A_ADDR = 16'h0020; A_WDATA = 16'h5555;
    @(negedge Clock);
    total++;
    if ({MEM_CS, MEM_RW, MEM_ADDR} !== {1'b1, 1'b1, 16'h0020}) begin
      bad++;
      $display("FAIL midrst_access: cs=%b rw=%b addr=%h, required 1 1 0020", MEM_CS, MEM_RW, MEM_ADDR);
    end
    Reset_n = 0;
    @(negedge Clock);
    Reset_n = 1;
    A_REQ = 0;
    total++;
    if ({MEM_CS, MEM_RW, MEM_ADDR, MEM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA} !== '0) begin
      bad++;
      $display("FAIL midrst_outputs: cs=%b rw=%b addr=%h wd=%h aack=%b back=%b ard=%h brd=%h, required all zero",
               MEM_CS, MEM_RW, MEM_ADDR, MEM_WDATA, A_ACK, B_ACK, A_RDATA, B_RDATA);
    end
    repeat (5) begin
      @(negedge Clock);
      if (A_ACK) ack_seen = 1;
    end
    total++;
    if (ack_seen) begin
      bad++;
      $display("FAIL midrst_no_ack: ack_seen=1, required 0");
    end
    A_REQ = 1; A_RW = 0; A_WDATA = 16'h0000;
    wait_ack(1'b0, lat);
    total++;
    if (lat !== 3 || A_RDATA !== 16'h5555) begin
      bad++;
      $display("FAIL midrst_readback: latency=%0d ardata=%h, required 3 5555", lat, A_RDATA);
    end
    A_REQ = 0;
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_write_readback();
    test_simultaneous();
    test_contention();
    test_back_to_back();
    test_reset_mid_access();
    repeat (2) @(negedge Clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
